wrr_arbiter: RTL
================

# wrr_arbiter

Parametrised weighted round-robin arbiter that selects which of `QUEUE_QUANTITY` input FIFOs drives the shared output path. It generalises the fixed 4-queue, one-word-per-turn round-robin selector:
- any queue count, including non-power-of-two;
- a per-queue burst weight, with weight 0 masking the queue;
- a registered grant held for a burst of consumer pops.

It sits between the per-queue FIFO `buf_empty` flags and the output mux/pop logic.

## Interface
- `QUEUE_QUANTITY`, default 4: number of queues, N ≥ 2.
- `WEIGHT_BITS`, default 3: width of each per-queue weight field.
- `SEL_BITS`, default `$clog2(QUEUE_QUANTITY)`: selector width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `enb`  in  1  block enable; 0 freezes all state and ignores `pop`.
- `buf_empty`  in  N  bit i = 1 when queue i is empty.
- `weights`  in  N*WEIGHT_BITS  weight of queue i is at bits [i*WEIGHT_BITS +: WEIGHT_BITS]. Weight 0 masks the queue.
- `pop`  in  1  consumer takes one word from the selected queue this cycle.
- `selector`  out  SEL_BITS  index of the granted queue; registered.
- `selector_enb`  out  1  equals `grant_q & enb & !buf_empty[selector]`; a word is available.
- `burst_last`  out  1  equals `selector_enb & (credit == 1)`; the current pop ends the burst.

## Operation
- Registers:
  - `state` ∈ {IDLE, GRANT};
  - `ptr` (SEL_BITS), the search start;
  - `selector` (SEL_BITS);
  - `credit` (WEIGHT_BITS);
  - `grant_q`, which is 1 iff state = GRANT.
- Eligibility: queue i is eligible when `!buf_empty[i] && weights[i] != 0`.
- Search: combinational, circular, first eligible index starting at `ptr`.
  - Order is ptr, ptr+1, …, wrapping from N-1 to 0, covering all N.
  - Index arithmetic is mod N, never mod 2^SEL_BITS.
- Reset values:
  - state = IDLE, `ptr` = 0, `selector` = 0, `credit` = 0, `grant_q` = 0;
  - therefore `selector_enb` = 0 and `burst_last` = 0.
- IDLE, at an edge with `enb`=1:
  - if any queue is eligible: `selector` ← found index, `credit` ← its weight, go to GRANT;
  - otherwise stay in IDLE.
- GRANT, at an edge with `enb`=1, evaluated in priority order:
  - `pop`=1 and `selector_enb`=1 and `credit`=1: burst ends.
  - `pop`=1 and `selector_enb`=1 and `credit`>1: `credit` ← `credit`-1, stay in GRANT.
  - `buf_empty[selector]`=1 and no valid pop: burst ends because the queue drained.
- Burst end: `ptr` ← `selector`+1, with N-1 wrapping to 0; state ← IDLE; `credit` ← 0.
- `pop` while `selector_enb`=0 is ignored; no state change.
- Weights are latched into `credit` at grant. Changing `weights` mid-burst affects only later grants.
- `enb`=0:
  - all registers hold;
  - `selector_enb` and `burst_last` read 0;
  - the burst resumes with its remaining credit when `enb` returns to 1.
- `rst` mid-burst: all registers return to reset values at that edge; the partial burst is discarded.

## Timing
- Grant latency: an eligible queue visible before edge t gives `selector`/`selector_enb` valid after edge t.
- Within a burst, one pop per cycle.
- The burst holds `selector` stable for up to weight consecutive pops.
- One IDLE bubble cycle after every burst end, so the next grant appears after edge t+1.
- Throughput with all queues full and all weights w: w words per w+1 cycles.
- `buf_empty` is the FIFO's registered flag:
  - after the pop that drains a queue, `selector_enb` drops in the next cycle through the combinational term;
  - the burst ends at the following edge.
- Last-credit pop and drain in the same cycle: treated as a single burst end; `ptr` advances once.

## Test plan
- **Reset, then all-full queues:** N=4, weights {1,1,1,1}, `pop`=1 continuously, all `buf_empty`=0.
  - `selector` sequence 0,1,2,3,0.
  - `selector_enb` pattern 1,0 repeating (bubble each burst).
- **Weighted burst:** weights {3,1,2,1}, all full, `pop`=1.
  - `selector` is 0 for 3 cycles, then 1 for 1, then 2 for 2, then 3 for 1.
  - `burst_last` is high on the final pop of each burst.
- **Early drain:** weights {4,1,1,1}; queue 0 holds 2 words, queue 1 holds words.
  - Queue 0 is granted; after 2 pops `selector_enb` drops.
  - Next grant is `selector`=1; `ptr`=1.
- **Masking and skip:** weights {0,2,0,2}, all full.
  - Only `selector` 1 and 3 are granted, alternating in bursts of 2.
  - With all queues empty, `selector_enb` stays 0.
- **Non-power-of-two and wrap:** N=3, weights {1,1,1}, all full.
  - `selector` 0,1,2,0; index 3 never appears.
  - `ptr` wraps 2→0.
- **Freeze and reset mid-burst:** weights {3,…}.
  - Drop `enb` after 1 pop for 3 cycles: `selector_enb`=0 and `credit` holds at 2.
  - Re-enable: 2 more pops on queue 0.
  - Pulse `rst` mid-burst: next cycle all outputs are 0 and `ptr`=0.

Source files
------------

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter over per-queue FIFO empty flags.
// Holds a registered grant for a burst of up to weight pops per queue.
module wrr_arbiter #(
    parameter int QUEUE_QUANTITY = 4,
    parameter int WEIGHT_BITS    = 3,
    parameter int SEL_BITS       = $clog2(QUEUE_QUANTITY)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  enb,
    input  logic [QUEUE_QUANTITY-1:0]             buf_empty,
    input  logic [QUEUE_QUANTITY*WEIGHT_BITS-1:0] weights,
    input  logic                                  pop,
    output logic [SEL_BITS-1:0]                   selector,
    output logic                                  selector_enb,
    output logic                                  burst_last
);

    localparam int N = QUEUE_QUANTITY;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state, state_d;
    logic [SEL_BITS-1:0]    ptr, ptr_d;
    logic [SEL_BITS-1:0]    selector_d;
    logic [WEIGHT_BITS-1:0] credit, credit_d;
    logic                   grant_q, grant_d;
    logic                   found;
    logic [SEL_BITS-1:0]    found_idx;
    logic [WEIGHT_BITS-1:0] found_w;
    logic                   cur_empty;
    logic                   end_burst;

    // Circular search for the first eligible queue starting at ptr (mod N).
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        found_idx = '0;
        found_w   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && !buf_empty[idx] &&
                weights[idx*WEIGHT_BITS +: WEIGHT_BITS] != '0) begin
                found     = 1'b1;
                found_idx = SEL_BITS'(idx);
                found_w   = weights[idx*WEIGHT_BITS +: WEIGHT_BITS];
            end
        end
    end

    // Word-available and last-pop flags for the granted queue.
    always_comb begin
        cur_empty    = buf_empty[selector];
        selector_enb = grant_q & enb & ~cur_empty;
        burst_last   = selector_enb & (credit == WEIGHT_BITS'(1));
    end

    // Next-state: grant on eligibility, count down credit, end on drain.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        selector_d = selector;
        credit_d   = credit;
        end_burst  = 1'b0;
        if (enb) begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        selector_d = found_idx;
                        credit_d   = found_w;
                        state_d    = GRANT;
                    end
                end
                GRANT: begin
                    if (pop && selector_enb) begin
                        if (credit == WEIGHT_BITS'(1)) end_burst = 1'b1;
                        else credit_d = credit - WEIGHT_BITS'(1);
                    end else if (cur_empty) begin
                        end_burst = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (end_burst) begin
            ptr_d    = (selector == SEL_BITS'(N-1)) ? '0
                                                    : selector + SEL_BITS'(1);
            state_d  = IDLE;
            credit_d = '0;
        end
        grant_d = (state_d == GRANT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= '0;
            selector <= '0;
            credit   <= '0;
            grant_q  <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            selector <= selector_d;
            credit   <= credit_d;
            grant_q  <= grant_d;
        end
    end

endmodule
